// File: rtl/key_irq_pkg.sv
// Shared types and helpers for the key interrupt aggregator.
// Mode enum, default debounce length, priority-encoder width.
package key_irq_pkg;

  typedef enum logic {
    IRQ_LEVEL = 1'b0,
    IRQ_EDGE  = 1'b1
  } irq_mode_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key channel: synchroniser, polarity normalise, debounce.
// Ports: clk, reset, key_in -> level, press_evt (release_evt
// only when KEY_IRQ_RELEASE_EN is defined).
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic key_in,
  output logic level,
`ifdef KEY_IRQ_RELEASE_EN
  output logic release_evt,
`endif
  output logic press_evt
);

  localparam int   CW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic REL = (ACTIVE_LOW != 0);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   prev;
  logic                   pressed;

  // Preset to the released pin level so reset never
  // looks like a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= {SYNC_STAGES{REL}};
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], key_in};
    end
  end

  assign pressed = sync[SYNC_STAGES-1] ^ REL;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
      prev  <= 1'b0;
    end else begin
      prev <= level;
      if (pressed != level) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          level <= ~level;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign press_evt = level & ~prev;
`ifdef KEY_IRQ_RELEASE_EN
  assign release_evt = ~level & prev;
`endif

endmodule

// File: rtl/key_irq_aggregator.sv
// N-channel key front-end driving the MCU external interrupt.
// Ports: keys_in, irq_mask/edge_mode/ack in; keys_debounced,
// irq_pending, irq_out, irq_id, irq_id_valid out.
// Option: KEY_IRQ_RELEASE_EN also latches release events.
module key_irq_aggregator
  import key_irq_pkg::*;
#(
  parameter int NUM_KEYS        = 5,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = 2,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_KEYS-1:0]           keys_in,
  input  logic [NUM_KEYS-1:0]           irq_mask,
  input  logic [NUM_KEYS-1:0]           irq_edge_mode,
  input  logic [NUM_KEYS-1:0]           irq_ack,
  output logic [NUM_KEYS-1:0]           keys_debounced,
  output logic [NUM_KEYS-1:0]           irq_pending,
  output logic                          irq_out,
  output logic [id_width(NUM_KEYS)-1:0] irq_id,
  output logic                          irq_id_valid
);

  localparam int IW = id_width(NUM_KEYS);

  logic [NUM_KEYS-1:0] press;
  logic [NUM_KEYS-1:0] set;
  logic [NUM_KEYS-1:0] active;
  logic [IW-1:0]       id_next;

`ifdef KEY_IRQ_RELEASE_EN
  logic [NUM_KEYS-1:0] rel;
`endif

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_db (
      .clk        (clk),
      .reset      (reset),
      .key_in     (keys_in[i]),
      .level      (keys_debounced[i]),
`ifdef KEY_IRQ_RELEASE_EN
      .release_evt(rel[i]),
`endif
      .press_evt  (press[i])
    );
  end

`ifdef KEY_IRQ_RELEASE_EN
  assign set = press | rel;
`else
  assign set = press;
`endif

  // Edge: sticky until ack, set beats ack.
  // Level: mirror debounced state, so edge->level reloads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_pending <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (irq_mode_t'(irq_edge_mode[i]) == IRQ_EDGE) begin
          irq_pending[i] <= set[i] |
                            (irq_pending[i] & ~irq_ack[i]);
        end else begin
          irq_pending[i] <= keys_debounced[i];
        end
      end
    end
  end

  assign active = irq_pending & irq_mask;

  always_comb begin
    id_next = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (active[i]) id_next = IW'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_out <= 1'b0;
      irq_id  <= '0;
    end else begin
      irq_out <= |active;
      irq_id  <= id_next;
    end
  end

  assign irq_id_valid = irq_out;

endmodule

// File: tb/tb_key_irq_aggregator.sv
// Directed bench for key_irq_aggregator (5 keys, debounce 4).
// Expectations queued at stimulus, popped at sample points.
module tb_key_irq_aggregator;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] keys_in = 5'b11111;
  logic [4:0] irq_mask = 5'b00000;
  logic [4:0] irq_edge_mode = 5'b11110;
  logic [4:0] irq_ack = 5'b00000;
  logic [4:0] keys_debounced;
  logic [4:0] irq_pending;
  logic       irq_out;
  logic [2:0] irq_id;
  logic       irq_id_valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [4:0] deb;
    logic [4:0] pend;
    logic       out;
    logic [2:0] id;
  } exp_t;

  exp_t       sb_q[$];
  logic [4:0] edeb = '0;
  logic [4:0] epend = '0;
  logic       eout = 1'b0;
  logic [2:0] eid = '0;

  key_irq_aggregator #(
    .NUM_KEYS       (5),
    .DEBOUNCE_CYCLES(4),
    .SYNC_STAGES    (2),
    .ACTIVE_LOW     (1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .keys_in       (keys_in),
    .irq_mask      (irq_mask),
    .irq_edge_mode (irq_edge_mode),
    .irq_ack       (irq_ack),
    .keys_debounced(keys_debounced),
    .irq_pending   (irq_pending),
    .irq_out       (irq_out),
    .irq_id        (irq_id),
    .irq_id_valid  (irq_id_valid)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag);
    exp_t e;
    e.tag  = tag;
    e.deb  = edeb;
    e.pend = epend;
    e.out  = eout;
    e.id   = eid;
    sb_q.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    e = sb_q.pop_front();
    checks++;
    assert (keys_debounced === e.deb) else begin
      errors++;
      $error("FAIL %s deb got %b want %b",
             e.tag, keys_debounced, e.deb);
    end
    checks++;
    assert (irq_pending === e.pend) else begin
      errors++;
      $error("FAIL %s pend got %b want %b",
             e.tag, irq_pending, e.pend);
    end
    checks++;
    assert (irq_out === e.out) else begin
      errors++;
      $error("FAIL %s out got %b want %b",
             e.tag, irq_out, e.out);
    end
    checks++;
    assert (irq_id === e.id) else begin
      errors++;
      $error("FAIL %s id got %0d want %0d",
             e.tag, irq_id, e.id);
    end
    checks++;
    assert (irq_id_valid === e.out) else begin
      errors++;
      $error("FAIL %s valid got %b want %b",
             e.tag, irq_id_valid, e.out);
    end
  endtask

  task automatic check(input string tag);
    push(tag);
    pop_cmp();
  endtask

  initial begin
    tick(2);
    #3 reset = 1'b1;
    #1 check("rst_async");
    tick(2);
    reset = 1'b0;
    tick(10);
    check("rst_hold");

    keys_in[2] = 1'b0;
    tick(5);
    check("deb_pre");
    tick(1);
    edeb = 5'b00100;
    check("deb_edge6");
    tick(1);
    epend = 5'b00100;
    check("pend2");
    keys_in[2] = 1'b1;
    tick(6);
    edeb = 5'b00000;
    check("deb_rel2");
    tick(2);
    irq_ack = 5'b00100;
    tick(1);
    irq_ack = '0;
    epend = '0;
    check("ack2");

    keys_in[0] = 1'b0;
    tick(3);
    keys_in[0] = 1'b1;
    tick(8);
    check("glitch0");

    irq_mask = 5'b00010;
    keys_in[1] = 1'b0;
    tick(6);
    edeb = 5'b00010;
    check("deb1");
    tick(1);
    epend = 5'b00010;
    check("pend1");
    tick(1);
    eout = 1'b1;
    eid = 3'd1;
    check("irq1");
    irq_ack = 5'b00010;
    tick(1);
    irq_ack = '0;
    epend = '0;
    check("ack1");
    tick(1);
    eout = 1'b0;
    eid = 3'd0;
    check("irq1_clr");

    keys_in[1] = 1'b1;
    tick(6);
    edeb = 5'b00000;
    check("rel1");
    tick(1);
`ifdef KEY_IRQ_RELEASE_EN
    epend = 5'b00010;
`endif
    check("rel1_evt");
    irq_ack = 5'b00010;
    tick(1);
    irq_ack = '0;
    epend = '0;
    tick(2);
    eout = 1'b0;
    eid = 3'd0;
    check("rel1_clr");

    keys_in[1] = 1'b0;
    tick(6);
    edeb = 5'b00010;
    irq_ack = 5'b00010;
    tick(1);
    irq_ack = '0;
    epend = 5'b00010;
    check("ack_collide");
    tick(1);
    eout = 1'b1;
    eid = 3'd1;
    check("collide_irq");
    irq_ack = 5'b00010;
    tick(1);
    irq_ack = '0;
    epend = '0;
    tick(1);
    eout = 1'b0;
    eid = 3'd0;
    check("collide_clr");

    keys_in[3] = 1'b0;
    keys_in[4] = 1'b0;
    tick(7);
    edeb = 5'b11010;
    epend = 5'b11000;
    check("pend34");
    irq_mask = 5'b11000;
    tick(1);
    eout = 1'b1;
    eid = 3'd3;
    check("prio3");
    irq_mask = 5'b10000;
    tick(1);
    eid = 3'd4;
    check("prio4");
    irq_mask = 5'b00000;
    tick(1);
    eout = 1'b0;
    eid = 3'd0;
    check("mask0");
    irq_ack = 5'b11000;
    tick(1);
    irq_ack = '0;
    epend = '0;
    check("ack34");

    irq_mask = 5'b00001;
    keys_in[0] = 1'b0;
    tick(6);
    edeb = 5'b11011;
    check("lvl_deb");
    tick(1);
    epend = 5'b00001;
    check("lvl_pend");
    irq_ack = 5'b00001;
    tick(1);
    irq_ack = '0;
    eout = 1'b1;
    eid = 3'd0;
    check("lvl_ack");
    keys_in[0] = 1'b1;
    tick(6);
    edeb = 5'b11010;
    check("lvl_rel_deb");
    tick(1);
    epend = 5'b00000;
    check("lvl_rel");
    tick(1);
    eout = 1'b0;
    check("lvl_out_clr");

    irq_edge_mode[3] = 1'b0;
    tick(1);
    epend = 5'b01000;
    check("mode_lvl");
    irq_edge_mode[3] = 1'b1;
    tick(1);
    check("mode_edge_keep");
    irq_ack = 5'b01000;
    tick(1);
    irq_ack = '0;
    epend = '0;
    check("mode_edge_ack");

    keys_in[1] = 1'b1;
    tick(6);
    edeb = 5'b11000;
    tick(1);
`ifdef KEY_IRQ_RELEASE_EN
    epend = 5'b00010;
`endif
    check("release_evt");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
